wb_writeback_sequencer: RTL and testbench

- Writeback stage: the writer end of the WB-to-DE register-file write bus that the decode stage consumes.
- Accepts retiring instructions from MEM through a valid/ready handshake into a small FIFO.
- Emits at most one architectural write per cycle, because DE applies either a GPR write or a CSR write per clock, never both.
- Splits dual-write instructions (CSRR/CSRW-style) into two beats, publishes a pending-destination bitmap for DE hazard checks, and counts retirements.

---
 rtl/wb_writeback_sequencer_pkg.sv | 41 ++++
 rtl/wb_writeback_sequencer_retire_fifo.sv | 76 +++++++
 rtl/wb_writeback_sequencer.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_wb_writeback_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_writeback_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// wb_writeback_sequencer_pkg
//   Shared definitions for the writeback sequencer slice:
//     - default field widths of a retiring-instruction record
//     - instruction type codes (TYPE_IDLE marks "no GPR write this beat")
//     - wb_entry_t : one retiring instruction as buffered by the WB FIFO
//     - wb_state_e : sequencer states (ISSUE, CSR_BEAT)
//   No ports (package).
// ---------------------------------------------------------------------------
package wb_writeback_sequencer_pkg;

    localparam int WB_DBITS      = 32;
    localparam int WB_REGNOBITS  = 5;
    localparam int WB_CSRNOBITS  = 4;
    localparam int WB_TYPENOBITS = 3;

    // Instruction type codes as seen by DE on type_I_WB.
    localparam logic [WB_TYPENOBITS-1:0] TYPE_IDLE = 3'd0;
    localparam logic [WB_TYPENOBITS-1:0] TYPE_R    = 3'd1;
    localparam logic [WB_TYPENOBITS-1:0] TYPE_I    = 3'd2;
    localparam logic [WB_TYPENOBITS-1:0] TYPE_S    = 3'd3;
    localparam logic [WB_TYPENOBITS-1:0] TYPE_U    = 3'd4;

    // wr_reg and rd are kept as the two most significant fields: the FIFO
    // exposes that top slice of every slot for pending-destination tracking.
    typedef struct packed {
        logic                     wr_reg;
        logic [WB_REGNOBITS-1:0]  rd;
        logic [WB_DBITS-1:0]      regval;
        logic                     wr_csr;
        logic [WB_CSRNOBITS-1:0]  csrno;
        logic [WB_DBITS-1:0]      csrval;
        logic [WB_TYPENOBITS-1:0] itype;
    } wb_entry_t;

    typedef enum logic [0:0] {
        ISSUE    = 1'b0,
        CSR_BEAT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_writeback_sequencer_retire_fifo.sv
// ---------------------------------------------------------------------------
// wb_retire_fifo
//   DEPTH-entry synchronous FIFO holding retiring instructions.
//   Pointers wrap modulo DEPTH (DEPTH must be a power of two, >= 2).
//   Ports:
//     clk, reset        clock, asynchronous active-high reset (empties FIFO)
//     i_push/i_push_data write one entry (caller guarantees not full)
//     i_pop             drop the head entry (caller guarantees not empty)
//     o_head            entry at the read pointer
//     o_rd_ptr/o_wr_ptr current read / write slot
//     o_count           number of buffered entries (0..DEPTH)
//     o_tags            top TAGW bits of every slot, for hazard-mask logic
// ---------------------------------------------------------------------------
module wb_retire_fifo
    import wb_writeback_sequencer_pkg::*;
#(
    parameter int WIDTH = $bits(wb_entry_t),
    parameter int TAGW  = 1 + WB_REGNOBITS,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH)-1:0]   o_rd_ptr,
    output logic [$clog2(DEPTH)-1:0]   o_wr_ptr,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [DEPTH-1:0][TAGW-1:0] o_tags
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CW   = PTRW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTRW-1:0]  r_rd_ptr;
    logic [PTRW-1:0]  r_wr_ptr;
    logic [CW-1:0]    r_count;

    // Payload storage needs no reset: occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTRW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTRW'(1);
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    always_comb begin
        o_tags = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_tags[i] = r_mem[i][WIDTH-1 -: TAGW];
        end
    end

    assign o_head   = r_mem[r_rd_ptr];
    assign o_rd_ptr = r_rd_ptr;
    assign o_wr_ptr = r_wr_ptr;
    assign o_count  = r_count;

endmodule

// File: rtl/wb_writeback_sequencer.sv
// ---------------------------------------------------------------------------
// wb_writeback_sequencer
//   Writer end of the WB-to-DE register-file write bus. Retiring
//   instructions arrive from MEM over in_valid/in_ready into a small FIFO;
//   at most one architectural write (GPR or CSR) is emitted per cycle, so
//   dual-write instructions are split into a GPR beat followed by a CSR beat.
//   Optional feature: define WB_PERF_EN to add cycle_count/stall_cycles.
//   Ports:
//     clk, reset                 clock, asynchronous active-high reset
//     in_valid/in_ready          MEM handshake
//     in_wr_reg,in_rd,in_regval  GPR write request of the retiring instr
//     in_wr_csr,in_csrno,in_csrval CSR write request
//     in_type                    instruction type code
//     wr_reg_WB,wregno_WB        GPR write strobe / index to DE
//     regval_WB                  write data (GPR or CSR beat)
//     wr_csr_WB,wcsrno_WB        CSR write strobe / index to DE
//     rd_WB                      GPR destination of the current beat
//     type_I_WB                  type of current beat, TYPE_IDLE if no GPR write
//     pending_rd_mask            GPRs accepted but not yet written
//     retire_count               instructions retired (wraps)
//     cycle_count, stall_cycles  (WB_PERF_EN only) free-running counters
// ---------------------------------------------------------------------------
module wb_writeback_sequencer
    import wb_writeback_sequencer_pkg::*;
#(
    parameter int DBITS      = 32,
    parameter int REGNOBITS  = 5,
    parameter int CSRNOBITS  = 4,
    parameter int TYPENOBITS = 3,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_wr_reg,
    input  logic [REGNOBITS-1:0]  in_rd,
    input  logic [DBITS-1:0]      in_regval,
    input  logic                  in_wr_csr,
    input  logic [CSRNOBITS-1:0]  in_csrno,
    input  logic [DBITS-1:0]      in_csrval,
    input  logic [TYPENOBITS-1:0] in_type,
    output logic                  wr_reg_WB,
    output logic [REGNOBITS-1:0]  wregno_WB,
    output logic [DBITS-1:0]      regval_WB,
    output logic                  wr_csr_WB,
    output logic [CSRNOBITS-1:0]  wcsrno_WB,
    output logic [REGNOBITS-1:0]  rd_WB,
    output logic [TYPENOBITS-1:0] type_I_WB,
    output logic [31:0]           pending_rd_mask,
    output logic [31:0]           retire_count
`ifdef WB_PERF_EN
    ,
    output logic [31:0]           cycle_count,
    output logic [31:0]           stall_cycles
`endif
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CW   = PTRW + 1;
    localparam int TAGW = 1 + REGNOBITS;

    localparam logic [0:0]            S_ISSUE     = ISSUE;
    localparam logic [0:0]            S_CSR_BEAT  = CSR_BEAT;
    localparam logic [TYPENOBITS-1:0] L_TYPE_IDLE = TYPENOBITS'(TYPE_IDLE);

    // Same layout as wb_entry_t, but sized by this instance's parameters.
    typedef struct packed {
        logic                  wr_reg;
        logic [REGNOBITS-1:0]  rd;
        logic [DBITS-1:0]      regval;
        logic                  wr_csr;
        logic [CSRNOBITS-1:0]  csrno;
        logic [DBITS-1:0]      csrval;
        logic [TYPENOBITS-1:0] itype;
    } entry_t;

    localparam int EW = $bits(entry_t);

    // ------------------------------------------------------------------
    // Intake and FIFO
    // ------------------------------------------------------------------
    entry_t                    w_in_entry;
    entry_t                    w_head;
    logic [EW-1:0]             w_head_bits;
    logic                      w_push;
    logic                      w_pop;
    logic [PTRW-1:0]           w_rd_ptr;
    logic [PTRW-1:0]           w_wr_ptr;
    logic [CW-1:0]             w_count;
    logic [DEPTH-1:0][TAGW-1:0] w_tags;
    logic                      w_head_valid;

    // A write to x0 is architecturally a no-op: drop the strobe at intake so
    // it neither emits a beat nor shows up in the hazard mask.
    always_comb begin
        w_in_entry        = '0;
        w_in_entry.wr_reg = in_wr_reg && (in_rd != '0);
        w_in_entry.rd     = in_rd;
        w_in_entry.regval = in_regval;
        w_in_entry.wr_csr = in_wr_csr;
        w_in_entry.csrno  = in_csrno;
        w_in_entry.csrval = in_csrval;
        w_in_entry.itype  = in_type;
    end

    // in_ready looks only at the registered count: a pop in a full cycle
    // does not open the door until the next cycle.
    assign in_ready     = (w_count != CW'(DEPTH));
    assign w_push       = in_valid && in_ready;
    assign w_head_valid = (w_count != '0);
    assign w_head       = w_head_bits;

    wb_retire_fifo #(
        .WIDTH (EW),
        .TAGW  (TAGW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_in_entry),
        .i_pop       (w_pop),
        .o_head      (w_head_bits),
        .o_rd_ptr    (w_rd_ptr),
        .o_wr_ptr    (w_wr_ptr),
        .o_count     (w_count),
        .o_tags      (w_tags)
    );

    // ------------------------------------------------------------------
    // Beat sequencer
    // ------------------------------------------------------------------
    logic [0:0]            r_state;
    logic [0:0]            w_state_next;
    logic                  r_wr_reg_WB,  w_wr_reg_next;
    logic [REGNOBITS-1:0]  r_wregno_WB,  w_wregno_next;
    logic [DBITS-1:0]      r_regval_WB,  w_regval_next;
    logic                  r_wr_csr_WB,  w_wr_csr_next;
    logic [CSRNOBITS-1:0]  r_wcsrno_WB,  w_wcsrno_next;
    logic [TYPENOBITS-1:0] r_type_I_WB,  w_type_next;
    logic [31:0]           r_pending_rd_mask, w_mask_next;
    logic [31:0]           r_retire_count;

    always_comb begin
        w_state_next  = r_state;
        w_pop         = 1'b0;
        w_wr_reg_next = 1'b0;
        w_wregno_next = '0;
        w_regval_next = '0;
        w_wr_csr_next = 1'b0;
        w_wcsrno_next = '0;
        w_type_next   = L_TYPE_IDLE;
        if (w_head_valid) begin
            if (r_state == S_CSR_BEAT) begin
                // Second half of a dual-write instruction.
                w_wr_csr_next = 1'b1;
                w_wcsrno_next = w_head.csrno;
                w_regval_next = w_head.csrval;
                w_pop         = 1'b1;
                w_state_next  = S_ISSUE;
            end else if (w_head.wr_reg) begin
                w_wr_reg_next = 1'b1;
                w_wregno_next = w_head.rd;
                w_regval_next = w_head.regval;
                w_type_next   = w_head.itype;
                if (w_head.wr_csr) begin
                    w_state_next = S_CSR_BEAT;
                end else begin
                    w_pop = 1'b1;
                end
            end else if (w_head.wr_csr) begin
                w_wr_csr_next = 1'b1;
                w_wcsrno_next = w_head.csrno;
                w_regval_next = w_head.csrval;
                w_pop         = 1'b1;
            end else begin
                // Store/branch: retire with no architectural write.
                w_pop = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending-destination mask, rebuilt from the FIFO contents as they will
    // be after this edge: include this edge's push, exclude this edge's pop,
    // and exclude a head whose GPR beat has just been emitted.
    // ------------------------------------------------------------------
    logic [PTRW-1:0]        w_rd_ptr_next;
    logic [CW-1:0]          w_count_next;
    logic [DEPTH-1:0]       w_slot_live;
    logic [DEPTH-1:0][31:0] w_slot_bits;

    assign w_rd_ptr_next = w_rd_ptr + PTRW'(w_pop);
    assign w_count_next  = w_count + CW'(w_push) - CW'(w_pop);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [TAGW-1:0]      w_tag;
        logic                 w_tag_wr;
        logic [REGNOBITS-1:0] w_tag_rd;
        logic [PTRW-1:0]      w_off;
        logic                 w_occupied;
        logic                 w_gpr_done;

        assign w_tag = (w_push && (w_wr_ptr == PTRW'(gi)))
                     ? {w_in_entry.wr_reg, w_in_entry.rd}
                     : w_tags[gi];
        assign w_tag_wr   = w_tag[TAGW-1];
        assign w_tag_rd   = w_tag[REGNOBITS-1:0];
        // Slot distance from the next head; occupied if within next count.
        assign w_off      = PTRW'(gi) - w_rd_ptr_next;
        assign w_occupied = (CW'(w_off) < w_count_next);
        assign w_gpr_done = (PTRW'(gi) == w_rd_ptr_next) && (w_state_next == S_CSR_BEAT);

        assign w_slot_live[gi] = w_occupied && w_tag_wr && !w_gpr_done;
        assign w_slot_bits[gi] = 32'd1 << w_tag_rd;
    end

    always_comb begin
        w_mask_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_slot_live[i]) begin
                w_mask_next = w_mask_next | w_slot_bits[i];
            end
        end
        w_mask_next[0] = 1'b0;
    end

    // ------------------------------------------------------------------
    // Registered write bus
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state           <= S_ISSUE;
            r_wr_reg_WB       <= 1'b0;
            r_wregno_WB       <= '0;
            r_regval_WB       <= '0;
            r_wr_csr_WB       <= 1'b0;
            r_wcsrno_WB       <= '0;
            r_type_I_WB       <= L_TYPE_IDLE;
            r_pending_rd_mask <= '0;
            r_retire_count    <= '0;
        end else begin
            r_state           <= w_state_next;
            r_wr_reg_WB       <= w_wr_reg_next;
            r_wregno_WB       <= w_wregno_next;
            r_regval_WB       <= w_regval_next;
            r_wr_csr_WB       <= w_wr_csr_next;
            r_wcsrno_WB       <= w_wcsrno_next;
            r_type_I_WB       <= w_type_next;
            r_pending_rd_mask <= w_mask_next;
            if (w_pop) begin
                r_retire_count <= r_retire_count + 32'd1;
            end
        end
    end

    assign wr_reg_WB       = r_wr_reg_WB;
    assign wregno_WB       = r_wregno_WB;
    assign regval_WB       = r_regval_WB;
    assign wr_csr_WB       = r_wr_csr_WB;
    assign wcsrno_WB       = r_wcsrno_WB;
    assign rd_WB           = r_wregno_WB;
    assign type_I_WB       = r_type_I_WB;
    assign pending_rd_mask = r_pending_rd_mask;
    assign retire_count    = r_retire_count;

`ifdef WB_PERF_EN
    logic [31:0] r_cycle_count;
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle_count  <= '0;
            r_stall_cycles <= '0;
        end else begin
            r_cycle_count <= r_cycle_count + 32'd1;
            if (in_valid && !in_ready) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign cycle_count  = r_cycle_count;
    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_wb_writeback_sequencer.sv
// ---------------------------------------------------------------------------
// tb_wb_writeback_sequencer
//   Directed, table-driven bench for wb_writeback_sequencer (default
//   parameters, DEPTH=2), plus hand-written multi-cycle sequences.
// ---------------------------------------------------------------------------
module tb_wb_writeback_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_wr_reg;
    logic [4:0]  in_rd;
    logic [31:0] in_regval;
    logic        in_wr_csr;
    logic [3:0]  in_csrno;
    logic [31:0] in_csrval;
    logic [2:0]  in_type;
    logic        wr_reg_WB;
    logic [4:0]  wregno_WB;
    logic [31:0] regval_WB;
    logic        wr_csr_WB;
    logic [3:0]  wcsrno_WB;
    logic [4:0]  rd_WB;
    logic [2:0]  type_I_WB;
    logic [31:0] pending_rd_mask;
    logic [31:0] retire_count;
`ifdef WB_PERF_EN
    logic [31:0] cycle_count;
    logic [31:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    wb_writeback_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_wr_reg       (in_wr_reg),
        .in_rd           (in_rd),
        .in_regval       (in_regval),
        .in_wr_csr       (in_wr_csr),
        .in_csrno        (in_csrno),
        .in_csrval       (in_csrval),
        .in_type         (in_type),
        .wr_reg_WB       (wr_reg_WB),
        .wregno_WB       (wregno_WB),
        .regval_WB       (regval_WB),
        .wr_csr_WB       (wr_csr_WB),
        .wcsrno_WB       (wcsrno_WB),
        .rd_WB           (rd_WB),
        .type_I_WB       (type_I_WB),
        .pending_rd_mask (pending_rd_mask),
        .retire_count    (retire_count)
`ifdef WB_PERF_EN
        ,
        .cycle_count     (cycle_count),
        .stall_cycles    (stall_cycles)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h want=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic wr, input logic [4:0] rd, input logic [31:0] rv,
                         input logic wc, input logic [3:0] cn, input logic [31:0] cv, input logic [2:0] ty);
        in_valid  = v;
        in_wr_reg = wr;
        in_rd     = rd;
        in_regval = rv;
        in_wr_csr = wc;
        in_csrno  = cn;
        in_csrval = cv;
        in_type   = ty;
    endtask

    typedef struct {
        logic        v;
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] rv;
        logic        wc;
        logic [3:0]  cn;
        logic [31:0] cv;
        logic [2:0]  ty;
        logic        e_wr;
        logic [4:0]  e_wn;
        logic [31:0] e_rv;
        logic        e_wc;
        logic [3:0]  e_cn;
        logic [2:0]  e_ty;
        logic [31:0] e_mask;
        logic [31:0] e_ret;
        logic        e_rdy;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    // Watchdog: the bench must always end.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // dual-write stream for the back-to-back sequence
        logic [4:0]  ds_rd [3];
        logic [31:0] ds_rv [3];
        logic [3:0]  ds_cn [3];
        logic [31:0] ds_cv [3];
        int          sent;
        int          beats;
        int          cyc;
        logic        saw_low;
        logic        acc;
        int          k;

        //            v  wr rd     rv            wc cn    cv            ty  | wr wn     rv            wc cn    ty    mask          ret    rdy
        vecs[0]  = '{1'b1,1'b1,5'd5, 32'h0000002A,1'b0,4'd0, 32'h0,       3'd2, 1'b0,5'd0, 32'h0,       1'b0,4'd0, 3'd0, 32'h00000020,32'd0, 1'b1};
        vecs[1]  = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,4'd0, 32'h0,       3'd0, 1'b1,5'd5, 32'h0000002A,1'b0,4'd0, 3'd2, 32'h0,       32'd1, 1'b1};
        vecs[2]  = '{1'b1,1'b1,5'd3, 32'h00000011,1'b1,4'd2, 32'h00000099,3'd2, 1'b0,5'd0, 32'h0,       1'b0,4'd0, 3'd0, 32'h00000008,32'd1, 1'b1};
        vecs[3]  = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,4'd0, 32'h0,       3'd0, 1'b1,5'd3, 32'h00000011,1'b0,4'd0, 3'd2, 32'h0,       32'd1, 1'b1};
        vecs[4]  = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,4'd0, 32'h0,       3'd0, 1'b0,5'd0, 32'h00000099,1'b1,4'd2, 3'd0, 32'h0,       32'd2, 1'b1};
        vecs[5]  = '{1'b1,1'b0,5'd7, 32'h00000055,1'b0,4'd0, 32'h0,       3'd3, 1'b0,5'd0, 32'h0,       1'b0,4'd0, 3'd0, 32'h0,       32'd2, 1'b1};
        vecs[6]  = '{1'b1,1'b1,5'd0, 32'h00000077,1'b0,4'd0, 32'h0,       3'd1, 1'b0,5'd0, 32'h0,       1'b0,4'd0, 3'd0, 32'h0,       32'd3, 1'b1};
        vecs[7]  = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,4'd0, 32'h0,       3'd0, 1'b0,5'd0, 32'h0,       1'b0,4'd0, 3'd0, 32'h0,       32'd4, 1'b1};
        vecs[8]  = '{1'b1,1'b0,5'd0, 32'h0,       1'b1,4'hF, 32'hDEADBEEF,3'd2, 1'b0,5'd0, 32'h0,       1'b0,4'd0, 3'd0, 32'h0,       32'd4, 1'b1};
        vecs[9]  = '{1'b1,1'b1,5'd31,32'h12345678,1'b0,4'd0, 32'h0,       3'd2, 1'b0,5'd0, 32'hDEADBEEF,1'b1,4'hF, 3'd0, 32'h80000000,32'd5, 1'b1};
        vecs[10] = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,4'd0, 32'h0,       3'd0, 1'b1,5'd31,32'h12345678,1'b0,4'd0, 3'd2, 32'h0,       32'd6, 1'b1};
        vecs[11] = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,4'd0, 32'h0,       3'd0, 1'b0,5'd0, 32'h0,       1'b0,4'd0, 3'd0, 32'h0,       32'd6, 1'b1};

        ds_rd = '{5'd10, 5'd11, 5'd12};
        ds_rv = '{32'h101, 32'h102, 32'h103};
        ds_cn = '{4'd4, 4'd5, 4'd6};
        ds_cv = '{32'h201, 32'h202, 32'h203};

        // ---------------- reset state ----------------
        reset = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 4'd0, 32'h0, 3'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_reg", 32'(wr_reg_WB), 32'd0);
        chk("rst_wr_csr", 32'(wr_csr_WB), 32'd0);
        chk("rst_regval", regval_WB, 32'd0);
        chk("rst_type",   32'(type_I_WB), 32'd0);
        chk("rst_mask",   pending_rd_mask, 32'd0);
        chk("rst_retire", retire_count, 32'd0);
        chk("rst_ready",  32'(in_ready), 32'd1);
        $display("reset state checked");
        @(negedge clk);
        reset = 1'b0;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].wr, vecs[i].rd, vecs[i].rv,
                  vecs[i].wc, vecs[i].cn, vecs[i].cv, vecs[i].ty);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wr_reg", i), 32'(wr_reg_WB), 32'(vecs[i].e_wr));
            chk($sformatf("v%0d_wregno", i), 32'(wregno_WB), 32'(vecs[i].e_wn));
            chk($sformatf("v%0d_rd_WB",  i), 32'(rd_WB),     32'(vecs[i].e_wn));
            chk($sformatf("v%0d_regval", i), regval_WB,      vecs[i].e_rv);
            chk($sformatf("v%0d_wr_csr", i), 32'(wr_csr_WB), 32'(vecs[i].e_wc));
            chk($sformatf("v%0d_wcsrno", i), 32'(wcsrno_WB), 32'(vecs[i].e_cn));
            chk($sformatf("v%0d_type",   i), 32'(type_I_WB), 32'(vecs[i].e_ty));
            chk($sformatf("v%0d_mask",   i), pending_rd_mask, vecs[i].e_mask);
            chk($sformatf("v%0d_retire", i), retire_count,   vecs[i].e_ret);
            chk($sformatf("v%0d_ready",  i), 32'(in_ready),  32'(vecs[i].e_rdy));
            $display("vec %0d: in_valid=%0d wr_reg_WB=%0d wregno=%0d wr_csr_WB=%0d wcsrno=%0d regval=0x%08h mask=0x%08h retired=%0d",
                     i, vecs[i].v, wr_reg_WB, wregno_WB, wr_csr_WB, wcsrno_WB, regval_WB, pending_rd_mask, retire_count);
        end

        // ---------------- back-to-back dual writes, in_valid held ----------------
        sent    = 0;
        beats   = 0;
        cyc     = 0;
        saw_low = 1'b0;
        while (beats < 6 && cyc < 40) begin
            @(negedge clk);
            if (sent < 3) begin
                drive(1'b1, 1'b1, ds_rd[sent], ds_rv[sent], 1'b1, ds_cn[sent], ds_cv[sent], 3'd2);
            end else begin
                drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 4'd0, 32'h0, 3'd0);
            end
            acc = in_valid && in_ready;
            if (in_valid && !in_ready) begin
                saw_low = 1'b1;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
            end
            cyc++;
            chk("b2b_excl", 32'(wr_reg_WB & wr_csr_WB), 32'd0);
            if (wr_reg_WB || wr_csr_WB) begin
                k = beats / 2;
                if ((beats % 2) == 0) begin
                    chk($sformatf("b2b_beat%0d_kind", beats), {30'd0, wr_reg_WB, wr_csr_WB}, 32'd2);
                    chk($sformatf("b2b_beat%0d_idx",  beats), 32'(wregno_WB), 32'(ds_rd[k]));
                    chk($sformatf("b2b_beat%0d_data", beats), regval_WB, ds_rv[k]);
                end else begin
                    chk($sformatf("b2b_beat%0d_kind", beats), {30'd0, wr_reg_WB, wr_csr_WB}, 32'd1);
                    chk($sformatf("b2b_beat%0d_idx",  beats), 32'(wcsrno_WB), 32'(ds_cn[k]));
                    chk($sformatf("b2b_beat%0d_data", beats), regval_WB, ds_cv[k]);
                end
                $display("b2b beat %0d: wr_reg_WB=%0d wr_csr_WB=%0d wregno=%0d wcsrno=%0d regval=0x%08h",
                         beats, wr_reg_WB, wr_csr_WB, wregno_WB, wcsrno_WB, regval_WB);
                beats++;
            end
        end
        chk("b2b_beats",   32'(beats), 32'd6);
        chk("b2b_sent",    32'(sent), 32'd3);
        chk("b2b_ready_dropped", 32'(saw_low), 32'd1);
        chk("b2b_retire",  retire_count, 32'd9);
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 4'd0, 32'h0, 3'd0);
        @(posedge clk);
        #1;
        chk("b2b_idle_wr_reg", 32'(wr_reg_WB), 32'd0);
        chk("b2b_idle_wr_csr", 32'(wr_csr_WB), 32'd0);
        chk("b2b_idle_mask",   pending_rd_mask, 32'd0);
        chk("b2b_idle_retire", retire_count, 32'd9);

        // ---------------- reset during CSR_BEAT ----------------
        @(negedge clk);
        drive(1'b1, 1'b1, 5'd9, 32'h000000AB, 1'b1, 4'd3, 32'h000000CD, 3'd2);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 4'd0, 32'h0, 3'd0);
        @(posedge clk);
        #1;
        chk("rstmid_gpr_beat", 32'(wr_reg_WB), 32'd1);
        chk("rstmid_gpr_idx",  32'(wregno_WB), 32'd9);
        reset = 1'b1;
        #1;
        chk("rstmid_wr_reg", 32'(wr_reg_WB), 32'd0);
        chk("rstmid_wr_csr", 32'(wr_csr_WB), 32'd0);
        chk("rstmid_regval", regval_WB, 32'd0);
        chk("rstmid_mask",   pending_rd_mask, 32'd0);
        chk("rstmid_retire", retire_count, 32'd0);
        $display("reset applied during CSR beat");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rstmid_after%0d_csr", c), 32'(wr_csr_WB), 32'd0);
            chk($sformatf("rstmid_after%0d_rdy", c), 32'(in_ready), 32'd1);
            chk($sformatf("rstmid_after%0d_ret", c), retire_count, 32'd0);
        end

`ifdef WB_PERF_EN
        // ---------------- performance counters ----------------
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 4'd1, 32'h2, 3'd2);
        repeat (21) @(posedge clk);
        #1;
        chk("perf_cycles", cycle_count, 32'd21);
        chk("perf_stalls", stall_cycles, 32'd10);
        $display("perf: cycle_count=%0d stall_cycles=%0d", cycle_count, stall_cycles);
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 4'd0, 32'h0, 3'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
